// File: rtl/qos_pkg.sv
// rtl/qos_pkg.sv - shared types and packet layout for the QoS queuing design
package qos_pkg;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_COLLECT = 2'd1,
    ST_HOLD    = 2'd2
  } qos_state_e;

  localparam int PKT_W    = 4;
  localparam int PKT_BITS = 4;

  localparam int BUF_SEL_HI = 3;
  localparam int BUF_SEL_LO = 2;
  localparam int PAYLOAD_HI = 1;
  localparam int PAYLOAD_LO = 0;

  function automatic logic [1:0] pkt_buf_sel(input logic [PKT_W-1:0] p);
    return p[BUF_SEL_HI:BUF_SEL_LO];
  endfunction

  function automatic logic [1:0] pkt_payload(input logic [PKT_W-1:0] p);
    return p[PAYLOAD_HI:PAYLOAD_LO];
  endfunction

endpackage

// File: rtl/button_debounce.sv
// rtl/button_debounce.sv - 2-FF synchronizer, debouncer and press pulse for one active-low button
module button_debounce #(
  parameter int unsigned DEBOUNCE_CYCLES = 1_000_000
) (
  input  logic clk,
  input  logic rst,
  input  logic btn_n,
  output logic press
);

  localparam int unsigned CNT_W = $clog2(DEBOUNCE_CYCLES + 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

  logic             sync1_q, sync2_q;
  logic             clean_q, clean_d;
  logic             press_q, press_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;

  // Any cycle where the synchronized level agrees with the clean level restarts the stability count.
  always_comb begin
    clean_d = clean_q;
    press_d = 1'b0;
    cnt_d   = '0;
    if (sync2_q != clean_q) begin
      if (cnt_q == CNT_LAST) begin
        clean_d = sync2_q;
        press_d = ~sync2_q;
      end else begin
        cnt_d = cnt_q + 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      sync1_q <= 1'b1;
      sync2_q <= 1'b1;
      clean_q <= 1'b1;
      press_q <= 1'b0;
      cnt_q   <= '0;
    end else begin
      sync1_q <= btn_n;
      sync2_q <= sync1_q;
      clean_q <= clean_d;
      press_q <= press_d;
      cnt_q   <= cnt_d;
    end
  end

  assign press = press_q;

endmodule

// File: rtl/qos_packet_entry.sv
// rtl/qos_packet_entry.sv - assembles 4-bit packets from three buttons and offers them over valid/ready
module qos_packet_entry
  import qos_pkg::*;
#(
  parameter int unsigned DEBOUNCE_CYCLES = 1_000_000,
  parameter int unsigned TIMEOUT_CYCLES  = 250_000_000
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             bin0,
  input  logic             bin1,
  output logic [PKT_W-1:0] pkt,
  output logic             pkt_valid,
  input  logic             pkt_ready,
  output logic             collecting,
  output logic [2:0]       bit_count,
  output logic             abort_pulse
);

  localparam int unsigned TMO_W = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [TMO_W-1:0] TMO_LAST = TMO_W'(TIMEOUT_CYCLES - 1);
  localparam logic [2:0] LAST_BIT = 3'(PKT_BITS - 1);

  logic ev_start, ev_b0, ev_b1;

  button_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_db_start (
    .clk(clk), .rst(rst), .btn_n(start), .press(ev_start)
  );
  button_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_db_bin0 (
    .clk(clk), .rst(rst), .btn_n(bin0), .press(ev_b0)
  );
  button_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_db_bin1 (
    .clk(clk), .rst(rst), .btn_n(bin1), .press(ev_b1)
  );

  qos_state_e       state_q, state_d;
  logic [PKT_W-1:0] shift_q, shift_d, shifted;
  logic [PKT_W-1:0] pkt_q, pkt_d;
  logic [2:0]       cnt_q, cnt_d;
  logic [TMO_W-1:0] tmo_q, tmo_d;
  logic             valid_q, valid_d;
  logic             abort_q, abort_d;

  always_comb begin
    state_d = state_q;
    shift_d = shift_q;
    pkt_d   = pkt_q;
    cnt_d   = cnt_q;
    tmo_d   = tmo_q;
    valid_d = valid_q;
    abort_d = 1'b0;
    shifted = {shift_q[PKT_W-2:0], ev_b1};
    case (state_q)
      ST_IDLE: begin
        if (ev_start) begin
          state_d = ST_COLLECT;
          shift_d = '0;
          cnt_d   = '0;
          tmo_d   = '0;
        end
      end
      ST_COLLECT: begin
        // Start wins over a same-cycle bin press; simultaneous bins cancel but still count as activity.
        if (ev_start) begin
          shift_d = '0;
          cnt_d   = '0;
          tmo_d   = '0;
        end else if (ev_b0 && ev_b1) begin
          tmo_d = '0;
        end else if (ev_b0 || ev_b1) begin
          shift_d = shifted;
          cnt_d   = cnt_q + 3'd1;
          tmo_d   = '0;
          if (cnt_q == LAST_BIT) begin
            state_d = ST_HOLD;
            pkt_d   = shifted;
            valid_d = 1'b1;
          end
        end else if (tmo_q == TMO_LAST) begin
          state_d = ST_IDLE;
          abort_d = 1'b1;
          cnt_d   = '0;
          tmo_d   = '0;
        end else begin
          tmo_d = tmo_q + 1'b1;
        end
      end
      ST_HOLD: begin
        if (pkt_ready) begin
          state_d = ST_IDLE;
          valid_d = 1'b0;
          cnt_d   = '0;
        end
      end
      default: begin
        state_d = ST_IDLE;
        valid_d = 1'b0;
        cnt_d   = '0;
        tmo_d   = '0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_IDLE;
      shift_q <= '0;
      pkt_q   <= '0;
      cnt_q   <= '0;
      tmo_q   <= '0;
      valid_q <= 1'b0;
      abort_q <= 1'b0;
    end else begin
      state_q <= state_d;
      shift_q <= shift_d;
      pkt_q   <= pkt_d;
      cnt_q   <= cnt_d;
      tmo_q   <= tmo_d;
      valid_q <= valid_d;
      abort_q <= abort_d;
    end
  end

  assign pkt         = pkt_q;
  assign pkt_valid   = valid_q;
  assign collecting  = (state_q == ST_COLLECT);
  assign bit_count   = cnt_q;
  assign abort_pulse = abort_q;

endmodule

// File: tb/tb_qos_packet_entry.sv
// tb/tb_qos_packet_entry.sv - directed scoreboard bench for qos_packet_entry
module tb_qos_packet_entry;

  localparam int D        = 4;
  localparam int T        = 100;
  localparam int HOLD_CYC = 10;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       start = 1'b1, bin0 = 1'b1, bin1 = 1'b1;
  logic [3:0] pkt;
  logic       pkt_valid;
  logic       pkt_ready = 1'b1;
  logic       collecting;
  logic [2:0] bit_count;
  logic       abort_pulse;

  int n_checks = 0;
  int n_errors = 0;
  int cyc = 0;
  int valid_hi = 0;
  int abort_n = 0;
  int abort_cyc = 0;
  int xfers = 0;
  int c0 = 0;
  logic bp_watch = 1'b0;
  logic [3:0] sb[$];
  logic [3:0] exp_pkt;

  qos_packet_entry #(.DEBOUNCE_CYCLES(D), .TIMEOUT_CYCLES(T)) dut (
    .clk(clk), .rst(rst), .start(start), .bin0(bin0), .bin1(bin1),
    .pkt(pkt), .pkt_valid(pkt_valid), .pkt_ready(pkt_ready),
    .collecting(collecting), .bit_count(bit_count), .abort_pulse(abort_pulse)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic step(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic press(input logic s, input logic b0, input logic b1);
    start = ~s;
    bin0  = ~b0;
    bin1  = ~b1;
    step(HOLD_CYC);
    start = 1'b1;
    bin0  = 1'b1;
    bin1  = 1'b1;
    step(HOLD_CYC);
  endtask

  always @(negedge clk) begin
    if (!rst) begin
      if (pkt_valid) valid_hi++;
      if (abort_pulse) begin
        abort_n++;
        abort_cyc = cyc;
      end
      if (bp_watch) begin
        n_checks++;
        assert (pkt_valid === 1'b1 && pkt === 4'b0110) else begin
          n_errors++;
          $error("FAIL backpressure_hold observed=%b/%b expected=1/0110", pkt_valid, pkt);
        end
      end
      if (pkt_valid && pkt_ready) begin
        n_checks++;
        assert (sb.size() != 0) else begin
          n_errors++;
          $error("FAIL unexpected_xfer observed=%b expected=none", pkt);
        end
        if (sb.size() != 0) begin
          exp_pkt = sb.pop_front();
          xfers++;
          n_checks++;
          assert (pkt === exp_pkt) else begin
            n_errors++;
            $error("FAIL xfer_pkt observed=%b expected=%b", pkt, exp_pkt);
          end
        end
      end
    end
  end

  initial begin
    step(3);
    rst = 1'b0;
    step(1);
    chk("rst_pkt", pkt, 4'b0000);
    chk("rst_valid", pkt_valid, 1'b0);
    chk("rst_collecting", collecting, 1'b0);
    chk("rst_bit_count", bit_count, 3'd0);
    chk("rst_abort", abort_pulse, 1'b0);

    // Clean entry with ready tied high.
    pkt_ready = 1'b1;
    valid_hi  = 0;
    press(1, 0, 0);
    chk("clean_collecting", collecting, 1'b1);
    chk("clean_cnt0", bit_count, 3'd0);
    press(0, 0, 1);
    press(0, 1, 0);
    press(0, 0, 1);
    chk("clean_cnt3", bit_count, 3'd3);
    sb.push_back(4'b1011);
    press(0, 0, 1);
    chk("clean_valid_cycles", valid_hi, 1);
    chk("clean_idle", collecting, 1'b0);
    chk("clean_cnt_after", bit_count, 3'd0);

    // Bounce on bin1, then restart and simultaneous presses.
    press(1, 0, 0);
    for (int i = 0; i < 5; i++) begin
      bin1 = 1'b0;
      step(2);
      bin1 = 1'b1;
      step(2);
    end
    chk("bounce_none", bit_count, 3'd0);
    bin1 = 1'b0;
    step(HOLD_CYC);
    chk("bounce_one", bit_count, 3'd1);
    bin1 = 1'b1;
    step(HOLD_CYC);
    chk("bounce_release", bit_count, 3'd1);
    press(0, 0, 1);
    chk("restart_cnt2", bit_count, 3'd2);
    press(0, 1, 1);
    chk("simul_cnt", bit_count, 3'd2);
    press(1, 0, 1);
    chk("restart_cnt0", bit_count, 3'd0);
    chk("restart_collecting", collecting, 1'b1);
    press(0, 1, 0);
    press(0, 1, 0);
    press(0, 1, 0);
    sb.push_back(4'b0000);
    press(0, 1, 0);
    chk("restart_idle", collecting, 1'b0);

    // Backpressure: packet held while bins are pressed.
    pkt_ready = 1'b0;
    press(1, 0, 0);
    press(0, 1, 0);
    press(0, 0, 1);
    press(0, 0, 1);
    sb.push_back(4'b0110);
    press(0, 1, 0);
    chk("bp_cnt4", bit_count, 3'd4);
    bp_watch = 1'b1;
    for (int i = 0; i < 6; i++) press(0, i[0], ~i[0]);
    bp_watch = 1'b0;
    chk("bp_pkt", pkt, 4'b0110);
    chk("bp_cnt_hold", bit_count, 3'd4);
    pkt_ready = 1'b1;
    step(1);
    chk("bp_valid_after", pkt_valid, 1'b0);
    chk("bp_cnt_after", bit_count, 3'd0);
    chk("bp_xfers", xfers, 3);

    // Timeout after a single bit.
    step(5);
    abort_n  = 0;
    valid_hi = 0;
    press(1, 0, 0);
    c0   = cyc;
    bin1 = 1'b0;
    step(HOLD_CYC);
    chk("tmo_cnt1", bit_count, 3'd1);
    bin1 = 1'b1;
    for (int i = 0; i < 200 && abort_n == 0; i++) step(1);
    step(5);
    chk("tmo_abort_count", abort_n, 1);
    chk("tmo_abort_cycle", abort_cyc, c0 + 2 + D + 1 + T);
    chk("tmo_collecting", collecting, 1'b0);
    chk("tmo_cnt0", bit_count, 3'd0);
    chk("tmo_no_valid", valid_hi, 0);

    // Reset while holding a packet.
    pkt_ready = 1'b0;
    press(1, 0, 0);
    press(0, 0, 1);
    press(0, 1, 0);
    press(0, 1, 0);
    press(0, 0, 1);
    chk("hold_valid", pkt_valid, 1'b1);
    chk("hold_pkt", pkt, 4'b1001);
    rst = 1'b1;
    step(1);
    rst = 1'b0;
    chk("midrst_valid", pkt_valid, 1'b0);
    chk("midrst_pkt", pkt, 4'b0000);
    chk("midrst_cnt", bit_count, 3'd0);
    pkt_ready = 1'b1;
    press(1, 0, 0);
    chk("post_rst_collecting", collecting, 1'b1);
    press(0, 0, 1);
    press(0, 0, 1);
    press(0, 1, 0);
    sb.push_back(4'b1100);
    press(0, 1, 0);
    step(5);
    chk("final_sb_empty", sb.size(), 0);
    chk("final_xfers", xfers, 4);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
